// File: rtl/periph_arbiter_pkg.sv
// Shared types for the two-requester peripheral arbiter: FSM states, grant
// identity and the read data returned when a target access times out.
package periph_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int          WAIT_CNT_W    = 16;

endpackage

// File: rtl/periph_arbiter.sv
// Round-robin arbiter sharing one peripheral target between requester A (CPU) and
// requester B (debug UART). Define PERIPH_ARBITER_TIMEOUT_EN for the BUSY-state timeout.
module periph_arbiter
  import periph_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_a_request,
  input  logic                  i_a_rw,
  input  logic [ADDR_WIDTH-1:0] i_a_address,
  input  logic [31:0]           i_a_wdata,
  output logic [31:0]           o_a_rdata,
  output logic                  o_a_ready,
  input  logic                  i_b_request,
  input  logic                  i_b_rw,
  input  logic [ADDR_WIDTH-1:0] i_b_address,
  input  logic [31:0]           i_b_wdata,
  output logic [31:0]           o_b_rdata,
  output logic                  o_b_ready,
  output logic                  o_request,
  output logic                  o_rw,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [31:0]           o_wdata,
  input  logic [31:0]           i_rdata,
  input  logic                  i_ready,
  output logic                  o_timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("periph_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t                state_reg;
  grant_t                grant_reg;
  grant_t                last_reg;
  logic                  request_reg;
  logic                  rw_reg;
  logic [ADDR_WIDTH-1:0] address_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           a_rdata_reg;
  logic [31:0]           b_rdata_reg;
  logic                  a_ready_reg;
  logic                  b_ready_reg;
  logic                  timeout_reg;

  logic                  pick_b;
  logic                  finish;
  logic                  timeout_hit;
  logic [31:0]           finish_rdata;

`ifdef PERIPH_ARBITER_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
`endif

  // On a tie the requester that was not served last wins.
  assign pick_b = i_b_request && (!i_a_request || last_reg == GRANT_A);

  // A target response in the expiry cycle takes priority over the timeout.
  always_comb begin
    finish      = 1'b0;
    timeout_hit = 1'b0;
    if (state_reg == BUSY) begin
      if (i_ready) begin
        finish = 1'b1;
      end
`ifdef PERIPH_ARBITER_TIMEOUT_EN
      else if (wait_cnt_reg == WAIT_LAST) begin
        finish      = 1'b1;
        timeout_hit = 1'b1;
      end
`endif
    end
    finish_rdata = timeout_hit ? TIMEOUT_RDATA : i_rdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      grant_reg   <= GRANT_A;
      last_reg    <= GRANT_B;
      request_reg <= 1'b0;
      rw_reg      <= 1'b0;
      address_reg <= '0;
      wdata_reg   <= '0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
      a_ready_reg <= 1'b0;
      b_ready_reg <= 1'b0;
      timeout_reg <= 1'b0;
`ifdef PERIPH_ARBITER_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      a_ready_reg <= 1'b0;
      b_ready_reg <= 1'b0;
      timeout_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (i_a_request || i_b_request) begin
            grant_reg   <= pick_b ? GRANT_B : GRANT_A;
            rw_reg      <= pick_b ? i_b_rw : i_a_rw;
            address_reg <= pick_b ? i_b_address : i_a_address;
            wdata_reg   <= pick_b ? i_b_wdata : i_a_wdata;
            request_reg <= 1'b1;
            state_reg   <= BUSY;
`ifdef PERIPH_ARBITER_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        BUSY: begin
          if (finish) begin
            request_reg <= 1'b0;
            last_reg    <= grant_reg;
            timeout_reg <= timeout_hit;
            state_reg   <= DONE;
            if (grant_reg == GRANT_A) begin
              a_rdata_reg <= finish_rdata;
              a_ready_reg <= 1'b1;
            end else begin
              b_rdata_reg <= finish_rdata;
              b_ready_reg <= 1'b1;
            end
          end
`ifdef PERIPH_ARBITER_TIMEOUT_EN
          else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          request_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_request = request_reg;
  assign o_rw      = rw_reg;
  assign o_address = address_reg;
  assign o_wdata   = wdata_reg;
  assign o_a_rdata = a_rdata_reg;
  assign o_b_rdata = b_rdata_reg;
  assign o_a_ready = a_ready_reg;
  assign o_b_ready = b_ready_reg;
  assign o_timeout = timeout_reg;

endmodule
